// File: rtl/folded_mult_pkg.sv
// folded_mult_pkg
//   Shared types for the folded multi-mode multiplier: the operating-mode
//   encoding, the controller state encoding and the column accumulator width
//   helper.
//   Optional feature macro used by the design: FOLDED_MULT_ADD_TERM_EN.
package folded_mult_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_LOW    = 2'd1,
    MODE_HIGH   = 2'd2,
    MODE_FULL   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_CARRY = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Column width: one product's high part plus headroom for every term that
  // can land in a single column (2*N product halves plus the addend).
  function automatic int out_bit_len(input int dsp_bit_len, input int word_len,
                                     input int num_elements);
    return 2 * dsp_bit_len - word_len + $clog2(2 * num_elements + 1);
  endfunction

endpackage

// File: rtl/folded_multi_mode_multiplier_row_mac.sv
// async_mult
//   Combinational W x W -> 2W unsigned multiplier (one DSP slice).
//   Ports: i_a, i_b operands; o_p full-width product.
//
// row_mac
//   One row of the folded multiplier: A[k] times every word of B, with each
//   product split at WORD_LEN and aligned onto the 2N result columns
//   (low part -> column k+j, high part -> column k+j+1).
//   Ports: i_k row index; i_a_word A[k]; i_b all B words; i_low_only drops
//   any contribution aimed at column >= N; o_row per-column row sums.
module async_mult #(
  parameter int W = 17
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  assign o_p = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};

endmodule

module row_mac
  import folded_mult_pkg::*;
#(
  parameter int NUM_ELEMENTS = 8,
  parameter int DSP_BIT_LEN  = 17,
  parameter int WORD_LEN     = 16,
  parameter int K_W          = 3,
  parameter int OUT_BIT_LEN  = out_bit_len(DSP_BIT_LEN, WORD_LEN, NUM_ELEMENTS)
) (
  input  logic [K_W-1:0]                                 i_k,
  input  logic [DSP_BIT_LEN-1:0]                         i_a_word,
  input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]       i_b,
  input  logic                                           i_low_only,
  output logic [2*NUM_ELEMENTS-1:0][OUT_BIT_LEN-1:0]     o_row
);

  logic [2*DSP_BIT_LEN-1:0] prod [NUM_ELEMENTS];

  for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_mult
    async_mult #(.W(DSP_BIT_LEN)) u_mult (
      .i_a (i_a_word),
      .i_b (i_b[j]),
      .o_p (prod[j])
    );
  end

  // Loop over columns with constant indices; the row offset only enters the
  // match condition, so no variable-index writes are needed.
  always_comb begin
    o_row = '0;
    for (int c = 0; c < 2 * NUM_ELEMENTS; c++) begin
      for (int j = 0; j < NUM_ELEMENTS; j++) begin
        if (!(i_low_only && c >= NUM_ELEMENTS)) begin
          if (int'(i_k) + j == c)
            o_row[c] = o_row[c] + OUT_BIT_LEN'(prod[j][WORD_LEN-1:0]);
          if (int'(i_k) + j + 1 == c)
            o_row[c] = o_row[c] + OUT_BIT_LEN'(prod[j][2*DSP_BIT_LEN-1:WORD_LEN]);
        end
      end
    end
  end

endmodule

// File: rtl/folded_multi_mode_multiplier.sv
// folded_multi_mode_multiplier
//   Folded N-word multiplier on redundant-form words: one row of N products
//   per cycle into 2N column accumulators, then a single carry pass into the
//   registered result. Modes: SQUARE (B := A), LOW (low N words only),
//   HIGH (upper N words shifted down), FULL (all 2N words).
//   Optional: define FOLDED_MULT_ADD_TERM_EN to add i_add_term into columns
//   0..N-1; without it the port and its adder input do not exist.
//   Ports: i_clk, i_rst_n (async, active low); i_val/o_rdy operand handshake
//   with i_mode, i_dat_a, i_dat_b[, i_add_term]; o_val/i_rdy result
//   handshake with o_dat (2N words).
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | ready; accept operands on i_val
//   ST_MUL   | accumulate row k of partial products, k = 0..N-1
//   ST_CARRY | fold column high bits into next column, load o_dat
//   ST_DONE  | hold result with o_val until i_rdy
module folded_multi_mode_multiplier
  import folded_mult_pkg::*;
#(
  parameter int NUM_ELEMENTS = 8,
  parameter int DSP_BIT_LEN  = 17,
  parameter int WORD_LEN     = 16
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_val,
  output logic                                        o_rdy,
  input  logic [1:0]                                  i_mode,
  input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    i_dat_a,
  input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    i_dat_b,
`ifdef FOLDED_MULT_ADD_TERM_EN
  input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    i_add_term,
`endif
  output logic                                        o_val,
  input  logic                                        i_rdy,
  output logic [2*NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]  o_dat
);

  localparam int OUT_BIT_LEN = out_bit_len(DSP_BIT_LEN, WORD_LEN, NUM_ELEMENTS);
  localparam int K_W         = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

  state_e state_q, state_d;
  mode_e  mode_q;
  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   a_q, b_q;
  logic [K_W-1:0]                             k_q;
  logic [2*NUM_ELEMENTS-1:0][OUT_BIT_LEN-1:0] col_q, col_nxt, row_sum;
  logic [2*NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] res, dat_d;
  logic last_row;

`ifdef FOLDED_MULT_ADD_TERM_EN
  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   add_q;
`endif

  assign last_row = (k_q == K_W'(NUM_ELEMENTS - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_val) state_d = ST_MUL;
      ST_MUL:   if (last_row) state_d = ST_CARRY;
      ST_CARRY: state_d = ST_DONE;
      ST_DONE:  if (i_rdy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_rdy = (state_q == ST_IDLE);
    o_val = (state_q == ST_DONE);
  end

  row_mac #(
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .DSP_BIT_LEN  (DSP_BIT_LEN),
    .WORD_LEN     (WORD_LEN),
    .K_W          (K_W),
    .OUT_BIT_LEN  (OUT_BIT_LEN)
  ) u_row_mac (
    .i_k        (k_q),
    .i_a_word   (a_q[k_q]),
    .i_b        (b_q),
    .i_low_only (mode_q == MODE_LOW),
    .o_row      (row_sum)
  );

  always_comb begin
    for (int c = 0; c < 2 * NUM_ELEMENTS; c++)
      col_nxt[c] = col_q[c] + row_sum[c];
`ifdef FOLDED_MULT_ADD_TERM_EN
    if (k_q == '0) begin
      for (int c = 0; c < NUM_ELEMENTS; c++)
        col_nxt[c] = col_nxt[c] + OUT_BIT_LEN'(add_q[c]);
    end
`endif
  end

  // Single carry pass: the high bits of the topmost column have no home and
  // are dropped, so results stay in redundant form.
  always_comb begin
    for (int i = 0; i < 2 * NUM_ELEMENTS; i++)
      res[i] = DSP_BIT_LEN'(col_q[i][WORD_LEN-1:0]);
    for (int i = 1; i < 2 * NUM_ELEMENTS; i++)
      res[i] = res[i] + DSP_BIT_LEN'(col_q[i-1][OUT_BIT_LEN-1:WORD_LEN]);
    dat_d = '0;
    case (mode_q)
      MODE_LOW:  for (int i = 0; i < NUM_ELEMENTS; i++) dat_d[i] = res[i];
      MODE_HIGH: for (int i = 0; i < NUM_ELEMENTS; i++) dat_d[i] = res[i+NUM_ELEMENTS];
      default:   dat_d = res;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q <= MODE_SQUARE;
      a_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      col_q  <= '0;
      o_dat  <= '0;
`ifdef FOLDED_MULT_ADD_TERM_EN
      add_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (i_val) begin
          mode_q <= mode_e'(i_mode);
          a_q    <= i_dat_a;
          b_q    <= (i_mode == MODE_SQUARE) ? i_dat_a : i_dat_b;
          k_q    <= '0;
          col_q  <= '0;
`ifdef FOLDED_MULT_ADD_TERM_EN
          add_q  <= i_add_term;
`endif
        end
        ST_MUL: begin
          col_q <= col_nxt;
          k_q   <= last_row ? '0 : k_q + 1'b1;
        end
        ST_CARRY: o_dat <= dat_d;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_folded_multi_mode_multiplier.sv
// Testbench for folded_multi_mode_multiplier (N=4, DSP=17, WORD=16).
// Expected results come from an integer/column model built from the
// multiplication rules, plus whole-number product checks.
module tb_folded_multi_mode_multiplier;
  localparam int N   = 4;
  localparam int DSP = 17;
  localparam int WRD = 16;
  localparam int LAT = N + 2;

  typedef logic [N-1:0][DSP-1:0]   vec_t;
  typedef logic [2*N-1:0][DSP-1:0] res_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_val = 1'b0;
  logic       i_rdy = 1'b0;
  logic       o_rdy, o_val;
  logic [1:0] i_mode = 2'd0;
  vec_t       i_dat_a = '0, i_dat_b = '0, add_term = '0;
  res_t       o_dat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  folded_multi_mode_multiplier #(
    .NUM_ELEMENTS (N),
    .DSP_BIT_LEN  (DSP),
    .WORD_LEN     (WRD)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_val      (i_val),
    .o_rdy      (o_rdy),
    .i_mode     (i_mode),
    .i_dat_a    (i_dat_a),
    .i_dat_b    (i_dat_b),
`ifdef FOLDED_MULT_ADD_TERM_EN
    .i_add_term (add_term),
`endif
    .o_val      (o_val),
    .i_rdy      (i_rdy),
    .o_dat      (o_dat)
  );

  function automatic vec_t rand_vec(input bit wide);
    vec_t v;
    for (int i = 0; i < N; i++)
      v[i] = DSP'(wide ? $urandom_range(0, 32'h1FFFF) : $urandom_range(0, 32'hFFFF));
    return v;
  endfunction

  function automatic vec_t eff_add(input vec_t add);
`ifdef FOLDED_MULT_ADD_TERM_EN
    return add;
`else
    return '0;
`endif
  endfunction

  function automatic logic [159:0] vec_int(input vec_t v);
    logic [159:0] s = '0;
    for (int i = 0; i < N; i++) s = s + (160'(v[i]) << (WRD * i));
    return s;
  endfunction

  function automatic logic [159:0] res_int(input res_t r, input int nw);
    logic [159:0] s = '0;
    for (int i = 0; i < nw; i++) s = s + (160'(r[i]) << (WRD * i));
    return s;
  endfunction

  // Column model: each product splits at bit 16 into columns k+j / k+j+1,
  // LOW drops anything aimed at the upper half, addend joins the lower
  // columns, then one carry pass.
  function automatic res_t model(input logic [1:0] mode, input vec_t a,
                                 input vec_t b_in, input vec_t add);
    longint col [2*N];
    longint p, w;
    vec_t   b;
    res_t   full, r;
    b = (mode == 2'd0) ? a : b_in;
    for (int c = 0; c < 2 * N; c++) col[c] = 0;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        p = longint'(a[k]) * longint'(b[j]);
        if (!(mode == 2'd1 && k + j >= N))     col[k+j]   += p % 65536;
        if (!(mode == 2'd1 && k + j + 1 >= N)) col[k+j+1] += p / 65536;
      end
    for (int c = 0; c < N; c++) col[c] += longint'(add[c]);
    for (int i = 0; i < 2 * N; i++) begin
      w = col[i] % 65536;
      if (i > 0) w += col[i-1] / 65536;
      full[i] = DSP'(w);
    end
    r = '0;
    case (mode)
      2'd1:    for (int i = 0; i < N; i++) r[i] = full[i];
      2'd2:    for (int i = 0; i < N; i++) r[i] = full[i+N];
      default: r = full;
    endcase
    return r;
  endfunction

  // Present one operation, wait for its result, hand it off. lat is the
  // cycle (accept cycle = 0) in which o_val is first seen.
  task automatic do_op(input logic [1:0] mode, input vec_t a, input vec_t b,
                       input vec_t add, output res_t dat, output int lat);
    int guard = 0;
    i_mode = mode; i_dat_a = a; i_dat_b = b; add_term = add; i_val = 1'b1;
    while (!o_rdy && guard < 50) begin @(posedge i_clk); #1; guard++; end
    @(posedge i_clk); #1;
    i_val = 1'b0;
    i_mode = 2'($urandom); i_dat_a = rand_vec(1); i_dat_b = rand_vec(1);
    add_term = rand_vec(1);
    lat = 1;
    while (!o_val && lat < 40) begin @(posedge i_clk); #1; lat++; end
    dat = o_dat;
    i_rdy = 1'b1;
    @(posedge i_clk); #1;
    i_rdy = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++;
    if (o_val !== 1'b0) begin n_fail++; $display("FAIL reset_o_val got %b want 0", o_val); end
    n_checks++;
    if (o_dat !== '0) begin n_fail++; $display("FAIL reset_o_dat got %h want 0", o_dat); end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_o_rdy got %b want 1", o_rdy); end
  endtask

  task automatic test_full_ones();
    int   exp_w [2*N] = '{1, 2, 3, 4, 3, 2, 1, 0};
    vec_t ones;
    res_t dat, exp;
    int   lat;
    for (int i = 0; i < N; i++) ones[i] = DSP'(1);
    for (int i = 0; i < 2 * N; i++) exp[i] = DSP'(exp_w[i]);
    do_op(2'd3, ones, ones, '0, dat, lat);
    n_checks++;
    if (dat !== exp) begin n_fail++; $display("FAIL full_ones got %h want %h", dat, exp); end
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL full_ones_latency got %0d want %0d", lat, LAT); end
    n_checks++;
    if (o_rdy !== 1'b1 || o_val !== 1'b0) begin
      n_fail++; $display("FAIL post_handshake got rdy=%b val=%b want rdy=1 val=0", o_rdy, o_val);
    end
  endtask

  task automatic test_square();
    vec_t a, b1, b2;
    res_t d1, d2;
    logic [159:0] want;
    int lat;
    for (int i = 0; i < N; i++) a[i] = DSP'(16'hFFFF);
    b1 = rand_vec(1); b2 = rand_vec(1);
    want = vec_int(a) * vec_int(a);
    do_op(2'd0, a, b1, '0, d1, lat);
    do_op(2'd0, a, b2, '0, d2, lat);
    n_checks++;
    if (res_int(d1, 2*N) !== want) begin
      n_fail++; $display("FAIL square_int got %h want %h", res_int(d1, 2*N), want);
    end
    n_checks++;
    if (d1 !== model(2'd0, a, b1, '0)) begin
      n_fail++; $display("FAIL square_words got %h want %h", d1, model(2'd0, a, b1, '0));
    end
    n_checks++;
    if (d2 !== d1) begin n_fail++; $display("FAIL square_b_unused got %h want %h", d2, d1); end
  endtask

  task automatic test_low();
    vec_t a, add;
    res_t d;
    logic [63:0] want;
    int lat;
    for (int i = 0; i < N; i++) a[i] = DSP'(16'hFFFF);
    add = '0; add[0] = DSP'(1);
    want = 64'(vec_int(a) * vec_int(a) + vec_int(eff_add(add)));
    do_op(2'd1, a, a, add, d, lat);
    n_checks++;
    if (d[2*N-1:N] !== '0) begin n_fail++; $display("FAIL low_upper got %h want 0", d[2*N-1:N]); end
    n_checks++;
    if (64'(res_int(d, N)) !== want) begin
      n_fail++; $display("FAIL low_int got %h want %h", 64'(res_int(d, N)), want);
    end
    n_checks++;
    if (d !== model(2'd1, a, a, eff_add(add))) begin
      n_fail++; $display("FAIL low_words got %h want %h", d, model(2'd1, a, a, eff_add(add)));
    end
  endtask

  task automatic test_high();
    vec_t a;
    res_t d, full;
    int   lat;
    a = '0; a[3] = DSP'(17'h10000);
    full = model(2'd3, a, a, '0);
    do_op(2'd2, a, a, '0, d, lat);
    n_checks++;
    if (d[N-1:0] !== full[2*N-1:N]) begin
      n_fail++; $display("FAIL high_words got %h want %h", d[N-1:0], full[2*N-1:N]);
    end
    n_checks++;
    if (d[2*N-1:N] !== '0) begin n_fail++; $display("FAIL high_upper got %h want 0", d[2*N-1:N]); end
  endtask

  task automatic test_stall();
    vec_t a, b;
    res_t exp;
    int   lat;
    a = rand_vec(1); b = rand_vec(1);
    exp = model(2'd3, a, b, '0);
    i_mode = 2'd3; i_dat_a = a; i_dat_b = b; add_term = '0; i_val = 1'b1;
    @(posedge i_clk); #1;
    i_val = 1'b0;
    lat = 1;
    while (!o_val && lat < 40) begin @(posedge i_clk); #1; lat++; end
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL stall_latency got %0d want %0d", lat, LAT); end
    for (int s = 0; s < 5; s++) begin
      i_val = 1'b1; i_mode = 2'($urandom); i_dat_a = rand_vec(1); i_dat_b = rand_vec(1);
      @(posedge i_clk); #1;
      n_checks++;
      if (o_val !== 1'b1 || o_rdy !== 1'b0 || o_dat !== exp) begin
        n_fail++;
        $display("FAIL stall_hold cyc %0d got val=%b rdy=%b dat=%h want val=1 rdy=0 dat=%h",
                 s, o_val, o_rdy, o_dat, exp);
      end
    end
    i_val = 1'b0; i_rdy = 1'b1;
    @(posedge i_clk); #1;
    i_rdy = 1'b0;
    n_checks++;
    if (o_val !== 1'b0 || o_rdy !== 1'b1) begin
      n_fail++; $display("FAIL stall_release got val=%b rdy=%b want val=0 rdy=1", o_val, o_rdy);
    end
  endtask

  task automatic test_mid_reset();
    vec_t a, b;
    res_t d;
    int   lat;
    i_mode = 2'd3; i_dat_a = rand_vec(1); i_dat_b = rand_vec(1); i_val = 1'b1;
    @(posedge i_clk); #1;          // accepted; row k=0 next
    i_val = 1'b0;
    @(posedge i_clk); #1;          // k=1
    @(posedge i_clk); #1;          // k=2
    i_rst_n = 1'b0;
    #2;
    n_checks++;
    if (o_val !== 1'b0 || o_dat !== '0) begin
      n_fail++; $display("FAIL midreset_clear got val=%b dat=%h want val=0 dat=0", o_val, o_dat);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_rdy !== 1'b1 || o_val !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle got rdy=%b val=%b want rdy=1 val=0", o_rdy, o_val);
    end
    a = rand_vec(0); b = rand_vec(0);
    do_op(2'd3, a, b, '0, d, lat);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL midreset_latency got %0d want %0d", lat, LAT); end
    n_checks++;
    if (res_int(d, 2*N) !== vec_int(a) * vec_int(b)) begin
      n_fail++; $display("FAIL midreset_result got %h want %h", res_int(d, 2*N), vec_int(a) * vec_int(b));
    end
  endtask

  task automatic test_random();
    vec_t a, b, add;
    res_t d, exp;
    logic [1:0] mode;
    int lat;
    for (int t = 0; t < 16; t++) begin
      mode = 2'(t % 4);
      a = rand_vec(t >= 8); b = rand_vec(t >= 8); add = rand_vec(t >= 8);
      exp = model(mode, a, b, eff_add(add));
      do_op(mode, a, b, add, d, lat);
      n_checks++;
      if (d !== exp || lat !== LAT) begin
        n_fail++;
        $display("FAIL random_%0d mode %0d got %h lat %0d want %h lat %0d", t, mode, d, lat, exp, LAT);
      end
      if (t < 8 && (mode == 2'd3 || mode == 2'd0)) begin
        n_checks++;
        if (res_int(d, 2*N) !== vec_int(a) * vec_int(mode == 2'd0 ? a : b) + vec_int(eff_add(add))) begin
          n_fail++; $display("FAIL random_int_%0d got %h", t, res_int(d, 2*N));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_ones();
    test_square();
    test_low();
    test_high();
    test_stall();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/folded_multi_mode_multiplier.md
FOLDED_MULTI_MODE_MULTIPLIER -- requirements
Module: folded_multi_mode_multiplier

Interface
REQ-001 SHALL have parameter NUM_ELEMENTS, default 8, meaning the number of operand words per input.
REQ-002 SHALL have parameter DSP_BIT_LEN, default 17, meaning the input/output word width in redundant form.
REQ-003 SHALL have parameter WORD_LEN, default 16, meaning the non-redundant word width and column split point.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; the ports are listed in REQ-005 and REQ-006.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; every register is rising-edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_val, input, 1 bit: the operands and mode are valid.
REQ-008 SHALL have port o_rdy, output, 1 bit: the block accepts operands.
REQ-009 SHALL have port i_mode, input, 2 bits: 0=SQUARE, 1=LOW, 2=HIGH, 3=FULL.
REQ-010 SHALL have port i_dat_a, input, DSP_BIT_LEN x NUM_ELEMENTS: operand A, word 0 least significant.
REQ-011 SHALL have port i_dat_b, input, DSP_BIT_LEN x NUM_ELEMENTS: operand B; it is ignored in SQUARE mode.
REQ-012 SHALL have port i_add_term, input, DSP_BIT_LEN x NUM_ELEMENTS: addend for columns 0..N-1; it exists only under REQ-031.
REQ-013 SHALL have port o_val, output, 1 bit: the result is valid.
REQ-014 SHALL have port i_rdy, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port o_dat, output, DSP_BIT_LEN x 2*NUM_ELEMENTS: the product in redundant form.

Function
REQ-016 SHALL implement a FSM with states IDLE, MUL, CARRY and DONE; o_rdy=1 only in IDLE.
REQ-017 SHALL, in IDLE when i_val=1, register A, mode and add term; B SHALL be registered as A in SQUARE mode; the FSM SHALL then go to MUL with row counter k=0 and all column accumulators cleared.
REQ-018 SHALL, in MUL, compute NUM_ELEMENTS DSP products A[k]*B[j] per cycle; each product's low WORD_LEN bits SHALL add into column k+j and its high bits into column k+j+1.
REQ-019 SHALL size the column accumulators at OUT_BIT_LEN = 2*DSP_BIT_LEN-WORD_LEN+clog2(2*NUM_ELEMENTS+1) bits, with no overflow for any input.
REQ-020 SHALL, in LOW mode, gate products and partial products that target column >= NUM_ELEMENTS to zero.
REQ-021 SHALL add the add term into columns 0..N-1 during row k=0.
REQ-022 SHALL go from MUL to CARRY after k=NUM_ELEMENTS-1.
REQ-023 SHALL, in CARRY, compute res[i] = col[i][WORD_LEN-1:0] + col[i-1][OUT_BIT_LEN-1:WORD_LEN] (col[-1]=0), register it into o_dat, then go to DONE.
REQ-024 SHALL, in HIGH mode, compute the full product; o_dat[i] SHALL be res[i+NUM_ELEMENTS] for i<N, and o_dat[N..2N-1] SHALL be 0.
REQ-025 SHALL, in LOW mode, drive o_dat[N..2N-1]=0; FULL and SQUARE SHALL output all 2N words.
REQ-026 SHALL assert o_val exactly NUM_ELEMENTS+2 cycles after the accepting edge.
REQ-027 SHALL hold o_val and o_dat stable in DONE until i_rdy=1, then return to IDLE; o_rdy SHALL rise the cycle after the output handshake, with no accept/output overlap.
REQ-028 SHALL ignore i_val, i_mode and all operand ports outside IDLE.

Reset
REQ-029 SHALL, while i_rst_n=0, force state=IDLE, o_rdy=1 after release, o_val=0, o_dat=0, k=0 and accumulators=0; mid-operation reset SHALL abort with no partial result visible.

Configuration
REQ-030 SHALL use the macro FOLDED_MULT_ADD_TERM_EN.
REQ-031 SHALL, with FOLDED_MULT_ADD_TERM_EN defined, include the i_add_term port and REQ-021; without it, SHALL omit the port, hardwire the addend to 0 and remove its adder input.

Structure
REQ-032 SHALL place the mode enum (SQUARE/LOW/HIGH/FULL), the FSM state enum and an OUT_BIT_LEN function in package folded_mult_pkg.
REQ-033 SHALL instantiate one sub-module, row_mac, per cycle as N async_mult instances plus column alignment; the FSM, accumulators and carry stage SHALL be in the top.

Verification (N=4, DSP=17, WORD=16)
REQ-034 SHALL check: FULL, A=B={1,1,1,1}, add=0 -> o_dat={1,2,3,4,3,2,1,0}, o_val at accept+6.
REQ-035 SHALL check: SQUARE, A={0xFFFF x4}, B=random -> o_dat equals A*A as integer and B is unused.
REQ-036 SHALL check: LOW, A=B={0xFFFF x4}, add={1,0,0,0} -> o_dat[4..7]=0 and the integer value of the low words = (A*A+1) mod 2^64.
REQ-037 SHALL check: HIGH, A=B={0,0,0,0x1_0000} -> o_dat[0..3] equal columns 4..7 of the full product and o_dat[4..7]=0.
REQ-038 SHALL check: i_rdy held 0 for 5 cycles in DONE -> o_val and o_dat stable, o_rdy=0, new i_val ignored.
REQ-039 SHALL check: i_rst_n pulsed at k=2 -> o_val=0, o_dat=0, next op correct with latency 6.
